// File: rtl/movement_pkg.sv
// Shared types for the movement front end: command codes, FSM states and
// the button priority encoder.
package movement_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_FWD,
    CMD_BWD,
    CMD_LEFT,
    CMD_RIGHT
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } in_state_t;

  // Fixed priority among debounced buttons: fwd > bwd > left > right.
  function automatic cmd_t pick_cmd(input logic f, input logic b,
                                    input logic l, input logic r);
    cmd_t c;
    c = CMD_NONE;
    if (f)      c = CMD_FWD;
    else if (b) c = CMD_BWD;
    else if (l) c = CMD_LEFT;
    else if (r) c = CMD_RIGHT;
    return c;
  endfunction

endpackage

// File: rtl/movement_input_ctrl_if.sv
// Button/enable inputs and command strobe outputs of movement_input_ctrl.
// The master side drives the buttons and consumes the strobes; the slave
// side is the controller itself.
interface movement_input_ctrl_if;
  logic btn_fwd_in;
  logic btn_bwd_in;
  logic btn_left_in;
  logic btn_right_in;
  logic enable_in;
  logic fwd_pulse;
  logic bwd_pulse;
  logic leftRot_pulse;
  logic rightRot_pulse;
  logic is_pulse;
  logic repeat_active;

  modport master (
    output btn_fwd_in, btn_bwd_in, btn_left_in, btn_right_in, enable_in,
    input  fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse,
           is_pulse, repeat_active
  );

  modport slave (
    input  btn_fwd_in, btn_bwd_in, btn_left_in, btn_right_in, enable_in,
    output fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse,
           is_pulse, repeat_active
  );
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a disagreement counter. The stable
// state flips only after the synchronized input has differed from it for
// DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic stable_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= btn_in;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Count consecutive disagreement; flip the stable state on the last one.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync_p1 != r_stable) begin
      if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync_p1;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign stable_out = r_stable;

endmodule

// File: rtl/movement_input_ctrl.sv
// Navigation button front end: debounces four buttons, picks one by
// priority, and emits single-cycle command strobes with hold-to-repeat.
// A gap counter keeps consecutive strobes at least MIN_GAP_CYCLES apart so
// the downstream multi-cycle update finishes before the next command.
module movement_input_ctrl
  import movement_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 500000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 10000000,
  parameter int MIN_GAP_CYCLES       = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  movement_input_ctrl_if.slave  bus
);

  localparam int TMR_W = $clog2((REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES);
  localparam int GAP_W = $clog2(MIN_GAP_CYCLES);
  localparam logic [TMR_W-1:0] TMR_DELAY_LD  = TMR_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_PERIOD_LD = TMR_W'(REPEAT_PERIOD_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LD        = GAP_W'(MIN_GAP_CYCLES - 1);

  logic w_deb_fwd, w_deb_bwd, w_deb_left, w_deb_right;
  logic w_any, w_held, w_gap_ok, w_fire;
  cmd_t w_pick, w_fire_cmd, w_cmd_nxt;
  in_state_t w_state_nxt;
  logic [TMR_W-1:0] w_tmr_nxt;

  in_state_t        r_state;
  cmd_t             r_cmd;
  logic [TMR_W-1:0] r_tmr;
  logic [GAP_W-1:0] r_gap;
  logic r_fwd_pulse, r_bwd_pulse, r_left_pulse, r_right_pulse, r_is_pulse;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_fwd (
    .clk_in(clk_in), .rst_in(rst_in), .btn_in(bus.btn_fwd_in), .stable_out(w_deb_fwd));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_bwd (
    .clk_in(clk_in), .rst_in(rst_in), .btn_in(bus.btn_bwd_in), .stable_out(w_deb_bwd));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk_in(clk_in), .rst_in(rst_in), .btn_in(bus.btn_left_in), .stable_out(w_deb_left));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk_in(clk_in), .rst_in(rst_in), .btn_in(bus.btn_right_in), .stable_out(w_deb_right));

  assign w_any    = w_deb_fwd | w_deb_bwd | w_deb_left | w_deb_right;
  assign w_pick   = pick_cmd(w_deb_fwd, w_deb_bwd, w_deb_left, w_deb_right);
  assign w_gap_ok = (r_gap == '0);

  // Debounced level of whichever button the current hold is tracking.
  always_comb begin
    w_held = 1'b0;
    case (r_cmd)
      CMD_FWD:   w_held = w_deb_fwd;
      CMD_BWD:   w_held = w_deb_bwd;
      CMD_LEFT:  w_held = w_deb_left;
      CMD_RIGHT: w_held = w_deb_right;
      default:   w_held = 1'b0;
    endcase
  end

  // Next state, latched command, repeat timer and strobe request.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_tmr_nxt   = r_tmr;
    w_fire      = 1'b0;
    w_fire_cmd  = CMD_NONE;
    if (!bus.enable_in) begin
      w_state_nxt = IDLE;
      w_cmd_nxt   = CMD_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any && w_gap_ok) begin
            w_fire      = 1'b1;
            w_fire_cmd  = w_pick;
            w_cmd_nxt   = w_pick;
            w_tmr_nxt   = TMR_DELAY_LD;
            w_state_nxt = DELAY;
          end
        end
        DELAY, REPEAT: begin
          // Release is checked before the timer so a let-go never repeats.
          if (!w_held) begin
            w_state_nxt = IDLE;
            w_cmd_nxt   = CMD_NONE;
          end else if (r_tmr != '0) begin
            w_tmr_nxt = r_tmr - TMR_W'(1);
          end else if (w_gap_ok) begin
            w_fire      = 1'b1;
            w_fire_cmd  = r_cmd;
            w_tmr_nxt   = TMR_PERIOD_LD;
            w_state_nxt = REPEAT;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cmd_nxt   = CMD_NONE;
        end
      endcase
    end
  end

  // FSM state, latched command and repeat timer.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_cmd   <= CMD_NONE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // Minimum spacing: reload on every strobe, count down and park at zero.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_gap <= '0;
    end else if (w_fire) begin
      r_gap <= GAP_LD;
    end else if (r_gap != '0) begin
      r_gap <= r_gap - GAP_W'(1);
    end
  end

  // Registered one-cycle strobes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_fwd_pulse   <= 1'b0;
      r_bwd_pulse   <= 1'b0;
      r_left_pulse  <= 1'b0;
      r_right_pulse <= 1'b0;
      r_is_pulse    <= 1'b0;
    end else begin
      r_fwd_pulse   <= w_fire && (w_fire_cmd == CMD_FWD);
      r_bwd_pulse   <= w_fire && (w_fire_cmd == CMD_BWD);
      r_left_pulse  <= w_fire && (w_fire_cmd == CMD_LEFT);
      r_right_pulse <= w_fire && (w_fire_cmd == CMD_RIGHT);
      r_is_pulse    <= w_fire;
    end
  end

  assign bus.fwd_pulse      = r_fwd_pulse;
  assign bus.bwd_pulse      = r_bwd_pulse;
  assign bus.leftRot_pulse  = r_left_pulse;
  assign bus.rightRot_pulse = r_right_pulse;
  assign bus.is_pulse       = r_is_pulse;
  assign bus.repeat_active  = (r_state == REPEAT);

endmodule

// File: doc/movement_input_ctrl.md
Name: movement_input_ctrl

Overview:
Front end for movement_control. It synchronizes and debounces the four raw navigation buttons and arbitrates between them. It produces the one-cycle command strobes fwd_pulse/bwd_pulse/leftRot_pulse/rightRot_pulse plus is_pulse, with hold-to-repeat. It also enforces a minimum spacing between strobes so that movement_control's multi-cycle update and map check always completes before the next command arrives.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized button must differ from its stable state before the stable state flips
REPEAT_DELAY_CYCLES, 25000000, cycles from the first strobe of a hold to the first repeat strobe
REPEAT_PERIOD_CYCLES, 10000000, cycles between subsequent repeat strobes; must be >= MIN_GAP_CYCLES
MIN_GAP_CYCLES, 8, minimum cycles between any two strobes; must be >= 4

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
btn_fwd_in  input  1  raw forward button, asynchronous, active-high
btn_bwd_in  input  1  raw backward button
btn_left_in  input  1  raw rotate-left button
btn_right_in  input  1  raw rotate-right button
enable_in  input  1  command generation enable
fwd_pulse  output  1  forward strobe
bwd_pulse  output  1  backward strobe
leftRot_pulse  output  1  rotate-left strobe
rightRot_pulse  output  1  rotate-right strobe
is_pulse  output  1  high in exactly the cycles where one direction strobe is high
repeat_active  output  1  high while in the REPEAT state

Behaviour:
- Reset (rst_in=0, asynchronous) clears the following, and they stay cleared while reset is held:
  - all synchronizer flops, debounce counters and stable states
  - the FSM, which goes to IDLE
  - the latched command, set to CMD_NONE
  - the gap counter
  - every output, all 0
- Synchronizer: 2 flops per button.
- Debounce, per button:
  - The counter increments each cycle that the synchronized value differs from the stable state; it clears on agreement.
  - When the count reaches DEBOUNCE_CYCLES, the stable state flips and the counter clears.
- Priority among debounced-high buttons: fwd > bwd > left > right.
- Gap counter:
  - Loaded with MIN_GAP_CYCLES-1 on every strobe; decrements to 0 and saturates there.
  - A strobe may issue only when the gap counter is 0. A strobe that is due while it is nonzero waits until it reaches 0 and is not dropped.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE: if any debounced button is high, enable_in=1 and gap=0, then issue a strobe for the highest-priority button, latch that command, load the timer with REPEAT_DELAY_CYCLES-1, and go to DELAY.
  - DELAY: if the latched button's debounced state is 0, go to IDLE with no strobe. Otherwise the timer decrements; at 0, issue a strobe for the latched command, load the timer with REPEAT_PERIOD_CYCLES-1, and go to REPEAT.
  - REPEAT: same release rule. At timer 0, issue a strobe and reload REPEAT_PERIOD_CYCLES-1.
  - Other buttons pressed during DELAY/REPEAT are ignored. After release of the latched button, IDLE picks up any button still held, level-based.
- enable_in=0 in any state: no strobes; the FSM goes to IDLE next cycle; debouncers keep running.
- Strobe outputs are registered, high for exactly one cycle, and exactly one direction strobe is high when is_pulse=1.
- Latency, counting edge 0 as the first posedge that samples the raw button high while it stays stable: the debounced state is high after edge DEBOUNCE_CYCLES+1, and the first strobe is visible after edge DEBOUNCE_CYCLES+2.
- Repeat timing: with the first strobe at edge E, repeats occur at E+REPEAT_DELAY_CYCLES, then every REPEAT_PERIOD_CYCLES.
- A release of 1 to DEBOUNCE_CYCLES-1 cycles is filtered out, so the hold continues uninterrupted.

Decomposition:
- Shared package movement_pkg:
  - cmd_t enum {CMD_NONE, CMD_FWD, CMD_BWD, CMD_LEFT, CMD_RIGHT}
  - in_state_t enum {IDLE, DELAY, REPEAT}
- One sub-module, button_debouncer (synchronizer plus counter, parameter DEBOUNCE_CYCLES), instantiated 4 times.
- Timer and gap counter widths are derived with $clog2 of the respective parameters.

Test Plan:
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=10, MIN_GAP_CYCLES=6 throughout.
- Reset: hold rst_in=0 with all buttons high -> all outputs 0 for the whole reset. Release -> first strobe after edge 6 relative to the first post-reset sampling edge.
- Single tap: btn_fwd high for 12 cycles -> exactly one fwd_pulse+is_pulse, 1 cycle wide, after edge 6; repeat_active stays 0.
- Hold: btn_left held 60 cycles -> leftRot_pulse at E, E+20, E+30, E+40 (and E+50 if still debounced high); repeat_active=1 from E+20 until 5 cycles after release.
- Glitch: btn_right high 3 cycles then low -> no strobe. Also a 2-cycle dropout during a hold -> the repeat cadence is unchanged.
- Priority and handover:
  - fwd and right pressed on the same cycle -> fwd_pulse only.
  - Release fwd while right is held -> rightRot_pulse no earlier than 6 cycles after the last fwd strobe.
- enable_in: deassert mid-REPEAT -> no strobes and FSM in IDLE. Reassert while held -> a new first strobe, followed by a fresh 20-cycle delay.
